// File: rtl/rggen_backdoor_arbiter_if.sv
// Requester, front-door status and backdoor port signals of the backdoor arbiter.
// The arbiter takes the slave modport; requesters/register block drive the master side.
interface rggen_backdoor_arbiter_if #(
  parameter int REQUESTERS = 2,
  parameter int DATA_WIDTH = 32
);
  logic [REQUESTERS-1:0]            i_request_valid;
  logic [REQUESTERS-1:0]            o_request_ready;
  logic [REQUESTERS-1:0]            i_request_write;
  logic [REQUESTERS*DATA_WIDTH-1:0] i_request_mask;
  logic [REQUESTERS*DATA_WIDTH-1:0] i_request_data;
  logic [REQUESTERS-1:0]            o_response_valid;
  logic                             o_response_error;
  logic [DATA_WIDTH-1:0]            o_response_data;
  logic                             i_frontdoor_busy;
  logic                             o_backdoor_valid;
  logic                             o_backdoor_write;
  logic [DATA_WIDTH-1:0]            o_backdoor_mask;
  logic [DATA_WIDTH-1:0]            o_backdoor_data;
  logic                             i_backdoor_ack;
  logic [DATA_WIDTH-1:0]            i_backdoor_data;

  modport slave (
    input  i_request_valid, i_request_write, i_request_mask, i_request_data,
    input  i_frontdoor_busy, i_backdoor_ack, i_backdoor_data,
    output o_request_ready, o_response_valid, o_response_error, o_response_data,
    output o_backdoor_valid, o_backdoor_write, o_backdoor_mask, o_backdoor_data
  );

  modport master (
    output i_request_valid, i_request_write, i_request_mask, i_request_data,
    output i_frontdoor_busy, i_backdoor_ack, i_backdoor_data,
    input  o_request_ready, o_response_valid, o_response_error, o_response_data,
    input  o_backdoor_valid, o_backdoor_write, o_backdoor_mask, o_backdoor_data
  );
endinterface

// File: rtl/rggen_backdoor_arbiter.sv
// Round-robin sharing of one rggen backdoor port: accept -> issue until ack/timeout -> one-cycle response.
// Grants only while no front-door access is in flight; peak rate is one access every three cycles.
module rggen_backdoor_arbiter #(
  parameter int REQUESTERS = 2,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 0
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  rggen_backdoor_arbiter_if.slave       bus
);
  localparam int GW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  state_e                  state;
  state_e                  state_next;
  logic [GW-1:0]           ptr;
  logic [GW-1:0]           grant;
  logic [GW-1:0]           sel;
  logic                    found;
  int                      idx;
  logic                    accept;
  logic                    expire;
  logic [CW-1:0]           count;
  logic                    write_q;
  logic [DATA_WIDTH-1:0]   mask_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [DATA_WIDTH-1:0]   resp_data;
  logic                    resp_error;
  logic [REQUESTERS-1:0]   ready;
  logic [REQUESTERS-1:0]   rsp_valid;
  logic                    bd_valid;

  // First valid channel at or after the pointer, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int i = 0; i < REQUESTERS; i++) begin
      idx = (int'(ptr) + i) % REQUESTERS;
      if (!found && bus.i_request_valid[idx]) begin
        found = 1'b1;
        sel   = GW'(idx);
      end
    end
  end

  if (TIMEOUT > 0) begin : g_wdog
    assign expire = (count == CW'(TIMEOUT - 1));
  end else begin : g_no_wdog
    assign expire = 1'b0;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    ready      = '0;
    rsp_valid  = '0;
    bd_valid   = 1'b0;
    case (state)
      IDLE: begin
        // Gated by reset so no accept strobe leaks out while held in reset.
        if (found && !bus.i_frontdoor_busy && i_rst_n) begin
          accept     = 1'b1;
          ready[sel] = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        bd_valid = 1'b1;
        if (bus.i_backdoor_ack || expire) begin
          state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid[grant] = 1'b1;
        state_next       = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      grant      <= '0;
      count      <= '0;
      write_q    <= 1'b0;
      mask_q     <= '0;
      data_q     <= '0;
      resp_data  <= '0;
      resp_error <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        grant   <= sel;
        write_q <= bus.i_request_write[sel];
        mask_q  <= bus.i_request_mask[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
        data_q  <= bus.i_request_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
        count   <= '0;
      end
      if (state == ISSUE) begin
        count <= count + 1'b1;
        // An ack in the expiry cycle wins over the timeout.
        if (bus.i_backdoor_ack) begin
          resp_data  <= bus.i_backdoor_data;
          resp_error <= 1'b0;
        end else if (expire) begin
          resp_data  <= '0;
          resp_error <= 1'b1;
        end
      end
      if (state == RESP) begin
        ptr <= (int'(grant) == REQUESTERS - 1) ? '0 : grant + 1'b1;
      end
    end
  end

  assign bus.o_request_ready  = ready;
  assign bus.o_response_valid = rsp_valid;
  assign bus.o_response_error = resp_error;
  assign bus.o_response_data  = resp_data;
  assign bus.o_backdoor_valid = bd_valid;
  assign bus.o_backdoor_write = write_q;
  assign bus.o_backdoor_mask  = mask_q;
  assign bus.o_backdoor_data  = data_q;
endmodule
